// File: rtl/lea128_round_key_gen.sv
// LEA-128 key schedule: streams the 24 192-bit round keys for one master key
// over a valid/ready handshake, one key per accepted transfer.
module lea128_round_key_gen #(
  parameter int ROUNDS = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic [191:0] rk,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [4:0]   rk_round,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OUT  = 1'b1
  } state_t;

  localparam logic [31:0] DELTA0 = 32'hc3efe9db;
  localparam logic [31:0] DELTA1 = 32'h44626b02;
  localparam logic [31:0] DELTA2 = 32'h79e27c8a;
  localparam logic [31:0] DELTA3 = 32'h78df30ec;
  localparam logic [4:0]  LAST_ROUND = 5'(ROUNDS - 1);

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  // Constant registers hold delta rotated by 4 per previous use, so the
  // residual rotation for round i is (i mod 4) plus the lane offset.
  function automatic logic [127:0] lea_step(input logic [127:0] t,
                                            input logic [31:0]  d,
                                            input logic [1:0]   off);
    logic [127:0] r;
    logic [4:0]   base;
    base       = {3'b000, off};
    r[31:0]    = rol32(t[31:0]   + rol32(d, base),         5'd1);
    r[63:32]   = rol32(t[63:32]  + rol32(d, base + 5'd1),  5'd3);
    r[95:64]   = rol32(t[95:64]  + rol32(d, base + 5'd2),  5'd6);
    r[127:96]  = rol32(t[127:96] + rol32(d, base + 5'd3),  5'd11);
    return r;
  endfunction

  state_t            state_r, state_n;
  logic [127:0]      t_r, t_n;
  logic [3:0][31:0]  c_r, c_n;
  logic [4:0]        round_r, round_n;
  logic              done_r, done_n;
  logic [4:0]        nxt_round_s;
  logic [1:0]        sel_s;

  assign nxt_round_s = round_r + 5'd1;
  assign sel_s       = nxt_round_s[1:0];

  // Next-state, key-state and constant-register update.
  always_comb begin
    state_n = state_r;
    t_n     = t_r;
    c_n     = c_r;
    round_n = round_r;
    done_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_OUT;
          t_n     = lea_step(key, DELTA0, 2'd0);
          c_n     = {DELTA3, DELTA2, DELTA1, rol32(DELTA0, 5'd4)};
          round_n = 5'd0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (rk_ready) begin
          if (round_r == LAST_ROUND) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            t_n        = lea_step(t_r, c_r[sel_s], sel_s);
            c_n[sel_s] = rol32(c_r[sel_s], 5'd4);
            round_n    = nxt_round_s;
          end
        end else begin
          state_n = ST_OUT;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      t_r     <= 128'd0;
      c_r     <= {DELTA3, DELTA2, DELTA1, DELTA0};
      round_r <= 5'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      t_r     <= t_n;
      c_r     <= c_n;
      round_r <= round_n;
      done_r  <= done_n;
    end
  end

  assign rk       = {t_r[63:32], t_r[127:96], t_r[63:32], t_r[95:64], t_r[63:32], t_r[31:0]};
  assign rk_valid = (state_r == ST_OUT);
  assign busy     = (state_r == ST_OUT);
  assign rk_round = round_r;
  assign done     = done_r;

endmodule

// File: tb/tb_lea128_round_key_gen.sv
// Self-checking bench for lea128_round_key_gen against a plain-arithmetic
// LEA-128 key-schedule model, with random keys and random backpressure.
module tb_lea128_round_key_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [191:0] rk;
  logic         rk_valid;
  logic         rk_ready;
  logic [4:0]   rk_round;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  delta [4] = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec};
  logic [191:0] exp_rk [24];

  always #5 clk = ~clk;

  lea128_round_key_gen #(.ROUNDS(24)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .rk       (rk),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    logic [63:0] w;
    w = {x, x} << (n % 32);
    return w[63:32];
  endfunction

  task automatic build_model(input logic [127:0] k);
    logic [31:0] t [4];
    int sh [4] = '{1, 3, 6, 11};
    for (int j = 0; j < 4; j++) t[j] = k[32*j +: 32];
    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < 4; j++) t[j] = rol(t[j] + rol(delta[i % 4], i + j), sh[j]);
      exp_rk[i] = {t[1], t[3], t[1], t[2], t[1], t[0]};
    end
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rk"},       rk,                 192'd0);
    chk({tag, "_rk_valid"}, 192'(rk_valid),     192'd0);
    chk({tag, "_rk_round"}, 192'(rk_round),     192'd0);
    chk({tag, "_busy"},     192'(busy),         192'd0);
    chk({tag, "_done"},     192'(done),         192'd0);
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one sequence; optionally stalls, injects a start in OUT, or resets at abort_at.
  task automatic do_seq(input logic [127:0] k, input bit stall, input int inject_at,
                        input int abort_at, input logic [191:0] rk0_ref,
                        input logic [191:0] rk0_mask);
    int  r;
    bit  rdy;
    bit  injected;
    logic [191:0] held;
    build_model(k);
    key      = k;
    start    = 1'b1;
    rk_ready = 1'b0;
    tick();
    start    = 1'b0;
    key      = rand_key();
    chk("rk0_ref", rk & rk0_mask, rk0_ref & rk0_mask);
    r        = 0;
    injected = 1'b0;
    for (int cyc = 0; cyc < 400 && r < 24; cyc++) begin
      if (r == abort_at) begin
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk_reset_outputs("abort");
        tick();
        chk_reset_outputs("abort_next");
        return;
      end
      chk("rk_valid", 192'(rk_valid), 192'd1);
      chk("busy",     192'(busy),     192'd1);
      chk("done_low", 192'(done),     192'd0);
      chk("rk_round", 192'(rk_round), 192'(r));
      chk("rk",       rk,             exp_rk[r]);
      rdy      = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      held     = rk;
      if (r == inject_at && !injected) begin
        start    = 1'b1;
        key      = rand_key();
        injected = 1'b1;
      end
      tick();
      start = 1'b0;
      if (rdy) r++;
      else chk("held_rk", rk, held);
    end
    chk("accepted_all", 192'(r),        192'd24);
    chk("done_pulse",   192'(done),     192'd1);
    chk("done_valid",   192'(rk_valid), 192'd0);
    chk("done_busy",    192'(busy),     192'd0);
  endtask

  logic [127:0] k_a;
  logic [127:0] k_b;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rk_ready = 1'b0;
    key      = 128'd0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    do_seq(128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f, 1'b0, -1, -1,
           192'h02497010_090d0883_02497010_194f7db1_02497010_003a0fd4, {192{1'b1}});
    tick();
    chk("done_one_cycle", 192'(done), 192'd0);

    do_seq(128'd0, 1'b0, -1, -1, 192'h3efe9dbc_87dfd3b7, 192'hffffffff_ffffffff);
    tick();

    k_a = rand_key();
    do_seq(k_a, 1'b0, -1, -1, 192'd0, 192'd0);
    tick();
    do_seq(k_a, 1'b1, -1, -1, 192'd0, 192'd0);
    tick();

    do_seq(rand_key(), 1'b1, 5, -1, 192'd0, 192'd0);
    tick();

    do_seq(rand_key(), 1'b0, -1, 10, 192'd0, 192'd0);
    do_seq(rand_key(), 1'b0, -1, -1, 192'd0, 192'd0);

    k_a = rand_key();
    k_b = rand_key();
    do_seq(k_a, 1'b0, -1, -1, 192'd0, 192'd0);
    do_seq(k_b, 1'b1, -1, -1, 192'd0, 192'd0);
    tick();
    chk("final_idle", 192'(busy), 192'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
